// File: rtl/local_injector.sv
// Packetizer between the local core and router input port 4. It builds head/body/tail
// flits, picks a free VC round-robin, and sends each flit stop-and-wait on per-VC acks.
module local_injector #(
  parameter int DATA_WIDTH = 64,
  parameter int VCH        = 4,
  parameter int VCH_NUM    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            my_xpos,
  input  logic [2:0]            my_ypos,
  input  logic                  test_set,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_dst_x,
  input  logic [2:0]            req_dst_y,
  input  logic [3:0]            req_len,
  input  logic                  pl_valid,
  output logic                  pl_ready,
  input  logic [DATA_WIDTH-3:0] pl_data,
  output logic [DATA_WIDTH-1:0] odata,
  output logic                  ovalid,
  output logic [VCH_NUM-1:0]    ovch,
  input  logic [VCH-1:0]        iack,
  input  logic [VCH-1:0]        irdy,
  input  logic [VCH-1:0]        ilck,
  output logic                  busy,
  output logic [15:0]           pkt_cnt,
  output logic [1:0]            dbg_state
);
  // Handshakes: a request, payload word or flit transfers in the cycle where both
  // sides are high (req_valid&req_ready, pl_valid&pl_ready, ovalid&iack[ovch]).
  typedef enum logic [1:0] {IDLE = 2'd0, VCSEL = 2'd1, SEND = 2'd2, LOAD = 2'd3} state_e;

  localparam int HDR_W = 18;

  state_e                  state_q, state_d;
  logic [VCH_NUM-1:0]      last_vc_q, last_vc_d;
  logic [VCH_NUM-1:0]      ovch_q, ovch_d;
  logic [DATA_WIDTH-1:0]   odata_q, odata_d;
  logic [3:0]              remaining_q, remaining_d;
  logic [15:0]             pkt_cnt_q, pkt_cnt_d;

  logic [VCH-1:0]          eligible;
  logic                    sel_found;
  logic [VCH_NUM-1:0]      sel_vc;
  logic [VCH_NUM-1:0]      idx;
  logic                    req_fire, pl_fire, ack_fire;
  logic [1:0]              head_type, body_type;

  assign req_ready = (state_q == IDLE) & ~test_set;
  assign pl_ready  = (state_q == LOAD) & ~test_set;
  assign ovalid    = (state_q == SEND) & irdy[ovch_q] & ~test_set;
  assign busy      = (state_q != IDLE);
  assign odata     = odata_q;
  assign ovch      = ovch_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign dbg_state = state_q;

  assign req_fire  = req_valid & req_ready;
  assign pl_fire   = pl_valid & pl_ready;
  assign ack_fire  = ovalid & iack[ovch_q];
  assign eligible  = irdy & ~ilck;
  assign head_type = (req_len == 4'd0) ? 2'b11 : 2'b01;
  assign body_type = (remaining_q == 4'd1) ? 2'b10 : 2'b00;

  // Round-robin: search begins one past the VC used by the previous packet.
  always_comb begin
    sel_found = 1'b0;
    sel_vc    = '0;
    idx       = '0;
    for (int i = 1; i <= VCH; i++) begin
      idx = VCH_NUM'((int'(last_vc_q) + i) % VCH);
      if (!sel_found && eligible[idx]) begin
        sel_found = 1'b1;
        sel_vc    = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_vc_d   = last_vc_q;
    ovch_d      = ovch_q;
    odata_d     = odata_q;
    remaining_d = remaining_q;
    pkt_cnt_d   = pkt_cnt_q;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          remaining_d = req_len;
          odata_d     = {head_type, req_dst_x, req_dst_y, my_xpos, my_ypos, req_len,
                         {(DATA_WIDTH-HDR_W){1'b0}}};
          state_d     = VCSEL;
        end
      end
      VCSEL: begin
        // The chosen VC stays owned until the final flit is acked; ilck is not rechecked.
        if (!test_set && sel_found) begin
          ovch_d    = sel_vc;
          last_vc_d = sel_vc;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (ack_fire) begin
          if (remaining_q == 4'd0) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            state_d   = IDLE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (pl_fire) begin
          odata_d     = {body_type, pl_data};
          remaining_d = remaining_q - 4'd1;
          state_d     = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_vc_q   <= VCH_NUM'(VCH - 1);
      ovch_q      <= '0;
      odata_q     <= '0;
      remaining_q <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_vc_q   <= last_vc_d;
      ovch_q      <= ovch_d;
      odata_q     <= odata_d;
      remaining_q <= remaining_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

endmodule

// File: tb/tb_local_injector.sv
// Directed bench for local_injector: head-only and payload packets, round-robin,
// VC stalls, test_set freeze and mid-packet reset.
module tb_local_injector;
  logic        clk;
  logic        reset;
  logic [2:0]  my_xpos, my_ypos;
  logic        test_set;
  logic        req_valid, req_ready;
  logic [2:0]  req_dst_x, req_dst_y;
  logic [3:0]  req_len;
  logic        pl_valid, pl_ready;
  logic [61:0] pl_data;
  logic [63:0] odata;
  logic        ovalid;
  logic [1:0]  ovch;
  logic [3:0]  iack, irdy, ilck;
  logic        busy;
  logic [15:0] pkt_cnt;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int pl_pulses = 0;

  logic [63:0] flit_q[$];
  logic [1:0]  vch_q[$];
  logic [61:0] pl_words[16];

  local_injector #(.DATA_WIDTH(64), .VCH(4), .VCH_NUM(2)) dut (
    .clk(clk), .reset(reset), .my_xpos(my_xpos), .my_ypos(my_ypos),
    .test_set(test_set), .req_valid(req_valid), .req_ready(req_ready),
    .req_dst_x(req_dst_x), .req_dst_y(req_dst_y), .req_len(req_len),
    .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
    .odata(odata), .ovalid(ovalid), .ovch(ovch), .iack(iack), .irdy(irdy),
    .ilck(ilck), .busy(busy), .pkt_cnt(pkt_cnt), .dbg_state(dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    #2;
    if (pl_ready === 1'b1) pl_pulses++;
  end

  function automatic logic [63:0] head_flit(input logic [2:0] dx, input logic [2:0] dy,
                                            input logic [3:0] len);
    logic [1:0] t;
    t = (len == 4'd0) ? 2'b11 : 2'b01;
    return {t, dx, dy, 3'd1, 3'd1, len, 46'd0};
  endfunction

  // driver tasks
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic do_request(input logic [2:0] dx, input logic [2:0] dy, input logic [3:0] len);
    int b;
    b = 0;
    @(negedge clk);
    req_dst_x = dx; req_dst_y = dy; req_len = len; req_valid = 1'b1;
    #1;
    while (req_ready !== 1'b1 && b < 50) begin @(negedge clk); #1; b++; end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL req_timeout: req_ready=%b required 1", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_ovalid(output bit ok);
    int b;
    b = 0;
    #1;
    while (ovalid !== 1'b1 && b < 50) begin @(negedge clk); #1; b++; end
    ok = (ovalid === 1'b1);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL ovalid_timeout: ovalid=%b required 1", ovalid);
    end
  endtask

  task automatic ack_flit(input int delay);
    repeat (delay) @(negedge clk);
    iack = 4'b0001 << ovch;
    @(negedge clk);
    iack = 4'b0000;
  endtask

  task automatic give_payload(input logic [61:0] w);
    int b;
    b = 0;
    pl_data = w; pl_valid = 1'b1;
    #1;
    while (pl_ready !== 1'b1 && b < 50) begin @(negedge clk); #1; b++; end
    n_checks++;
    if (pl_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL pl_timeout: pl_ready=%b required 1", pl_ready);
    end
    @(negedge clk);
    pl_valid = 1'b0;
  endtask

  task automatic run_packet(input logic [2:0] dx, input logic [2:0] dy, input logic [3:0] len,
                            input int delay);
    bit ok;
    flit_q.delete();
    vch_q.delete();
    do_request(dx, dy, len);
    for (int i = 0; i <= int'(len); i++) begin
      wait_ovalid(ok);
      if (!ok) return;
      flit_q.push_back(odata);
      vch_q.push_back(ovch);
      ack_flit(delay);
      if (i < int'(len)) give_payload(pl_words[i]);
    end
  endtask

  // scenarios
  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (odata !== 64'd0) begin n_fail++; $display("FAIL rst_odata: got %h exp 0", odata); end
    n_checks++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL rst_ovalid: got %b exp 0", ovalid); end
    n_checks++; if (ovch !== 2'd0) begin n_fail++; $display("FAIL rst_ovch: got %0d exp 0", ovch); end
    n_checks++; if (pl_ready !== 1'b0) begin n_fail++; $display("FAIL rst_pl_ready: got %b exp 0", pl_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy); end
    n_checks++; if (pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_pkt_cnt: got %0d exp 0", pkt_cnt); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b exp 1", req_ready); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_head_only();
    @(negedge clk);
    req_dst_x = 3'd2; req_dst_y = 3'd3; req_len = 4'd0; req_valid = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL ho_req_ready: got %b exp 1", req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b1 || ovalid !== 1'b0) begin n_fail++; $display("FAIL ho_cycle1: busy=%b ovalid=%b exp 1/0", busy, ovalid); end
    @(negedge clk);
    #1;
    n_checks++; if (ovalid !== 1'b1) begin n_fail++; $display("FAIL ho_cycle2_valid: got %b exp 1", ovalid); end
    n_checks++; if (odata !== 64'hD324_0000_0000_0000) begin n_fail++; $display("FAIL ho_flit: got %h exp d324000000000000", odata); end
    n_checks++; if (ovch !== 2'd0) begin n_fail++; $display("FAIL ho_vc: got %0d exp 0", ovch); end
    iack = 4'b0001;
    @(negedge clk);
    iack = 4'b0000;
    #1;
    n_checks++; if (busy !== 1'b0 || pkt_cnt !== 16'd1) begin n_fail++; $display("FAIL ho_cycle3: busy=%b pkt_cnt=%0d exp 0/1", busy, pkt_cnt); end
    n_checks++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL ho_ovalid_off: got %b exp 0", ovalid); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_vc;
    apply_reset();
    for (int p = 0; p < 3; p++) begin
      exp_vc = 2'(p);
      run_packet(3'(p + 4), 3'(7 - p), 4'd0, 0);
      n_checks++; if (vch_q.size() != 1 || vch_q[0] !== exp_vc) begin n_fail++; $display("FAIL b2b_vc%0d: got %0d exp %0d", p, vch_q[0], exp_vc); end
      n_checks++; if (flit_q[0] !== head_flit(3'(p + 4), 3'(7 - p), 4'd0)) begin n_fail++; $display("FAIL b2b_flit%0d: got %h exp %h", p, flit_q[0], head_flit(3'(p + 4), 3'(7 - p), 4'd0)); end
    end
    #1;
    n_checks++; if (pkt_cnt !== 16'd3) begin n_fail++; $display("FAIL b2b_pkt_cnt: got %0d exp 3", pkt_cnt); end
  endtask

  task automatic test_payload();
    logic [63:0] exp_f[4];
    int base;
    pl_words[0] = 62'h1234_5678_9ABC_DEF0;
    pl_words[1] = 62'h0BBB_0000_1111_2222;
    pl_words[2] = 62'h3CCC_DDDD_EEEE_FFFF;
    exp_f[0] = head_flit(3'd5, 3'd6, 4'd3);
    exp_f[1] = {2'b00, pl_words[0]};
    exp_f[2] = {2'b00, pl_words[1]};
    exp_f[3] = {2'b10, pl_words[2]};
    base = pl_pulses;
    run_packet(3'd5, 3'd6, 4'd3, 1);
    n_checks++; if (flit_q.size() != 4) begin n_fail++; $display("FAIL pl_count: got %0d flits exp 4", flit_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (flit_q[i] !== exp_f[i]) begin n_fail++; $display("FAIL pl_flit%0d: got %h exp %h", i, flit_q[i], exp_f[i]); end
      n_checks++; if (vch_q[i] !== 2'd3) begin n_fail++; $display("FAIL pl_vc%0d: got %0d exp 3", i, vch_q[i]); end
    end
    #1;
    n_checks++; if (pl_pulses - base != 3) begin n_fail++; $display("FAIL pl_ready_pulses: got %0d exp 3", pl_pulses - base); end
    n_checks++; if (pkt_cnt !== 16'd4) begin n_fail++; $display("FAIL pl_pkt_cnt: got %0d exp 4", pkt_cnt); end
  endtask

  task automatic test_rr_skip();
    ilck = 4'b0001;
    irdy = 4'b0111;
    run_packet(3'd0, 3'd7, 4'd0, 0);
    n_checks++; if (vch_q.size() != 1 || vch_q[0] !== 2'd1) begin n_fail++; $display("FAIL rr_skip_vc: got %0d exp 1", vch_q[0]); end
    ilck = 4'b0000;
    irdy = 4'b1111;
  endtask

  task automatic test_no_eligible();
    logic [63:0] held;
    irdy = 4'b0000;
    do_request(3'd6, 3'd1, 4'd0);
    repeat (3) begin
      #1;
      n_checks++; if (dbg_state !== 2'd1 || ovalid !== 1'b0) begin n_fail++; $display("FAIL ne_hold: state=%0d ovalid=%b exp 1/0", dbg_state, ovalid); end
      @(negedge clk);
    end
    irdy = 4'b0100;
    #1;
    n_checks++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL ne_same_cycle: ovalid=%b exp 0", ovalid); end
    @(negedge clk);
    #1;
    n_checks++; if (ovalid !== 1'b1 || ovch !== 2'd2) begin n_fail++; $display("FAIL ne_vc2: ovalid=%b ovch=%0d exp 1/2", ovalid, ovch); end
    held = odata;
    irdy = 4'b0000;
    #1;
    n_checks++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL ne_irdy_drop: ovalid=%b exp 0", ovalid); end
    n_checks++; if (odata !== head_flit(3'd6, 3'd1, 4'd0) || odata !== held) begin n_fail++; $display("FAIL ne_flit_held: got %h exp %h", odata, head_flit(3'd6, 3'd1, 4'd0)); end
    irdy = 4'b0100;
    ack_flit(0);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ne_done: busy=%b exp 0", busy); end
    irdy = 4'b1111;
  endtask

  task automatic test_test_set();
    bit ok;
    logic [15:0] base;
    logic [61:0] wa, wb;
    wa = 62'h2AAA_5555_0F0F_F0F0;
    wb = 62'h1357_9BDF_2468_ACE0;
    base = pkt_cnt;
    do_request(3'd4, 3'd0, 4'd2);
    wait_ovalid(ok);
    n_checks++; if (odata !== head_flit(3'd4, 3'd0, 4'd2) || ovch !== 2'd3) begin n_fail++; $display("FAIL ts_head: got %h vc %0d exp %h vc 3", odata, ovch, head_flit(3'd4, 3'd0, 4'd2)); end
    ack_flit(0);
    give_payload(wa);
    #1;
    n_checks++; if (ovalid !== 1'b1 || odata !== {2'b00, wa}) begin n_fail++; $display("FAIL ts_body: ovalid=%b got %h exp %h", ovalid, odata, {2'b00, wa}); end
    test_set = 1'b1;
    #1;
    n_checks++; if (ovalid !== 1'b0 || pl_ready !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL ts_gate: ovalid=%b pl_ready=%b req_ready=%b exp 0/0/0", ovalid, pl_ready, req_ready); end
    iack = 4'b1000;
    repeat (3) begin
      @(negedge clk);
      #1;
      n_checks++; if (dbg_state !== 2'd2 || busy !== 1'b1 || odata !== {2'b00, wa}) begin n_fail++; $display("FAIL ts_frozen: state=%0d busy=%b odata=%h exp 2/1/%h", dbg_state, busy, odata, {2'b00, wa}); end
    end
    iack = 4'b0000;
    @(negedge clk);
    test_set = 1'b0;
    #1;
    n_checks++; if (ovalid !== 1'b1 || ovch !== 2'd3 || odata !== {2'b00, wa}) begin n_fail++; $display("FAIL ts_resume: ovalid=%b ovch=%0d odata=%h exp 1/3/%h", ovalid, ovch, odata, {2'b00, wa}); end
    ack_flit(0);
    give_payload(wb);
    wait_ovalid(ok);
    n_checks++; if (odata !== {2'b10, wb} || ovch !== 2'd3) begin n_fail++; $display("FAIL ts_tail: got %h vc %0d exp %h vc 3", odata, ovch, {2'b10, wb}); end
    ack_flit(0);
    #1;
    n_checks++; if (busy !== 1'b0 || pkt_cnt !== base + 16'd1) begin n_fail++; $display("FAIL ts_done: busy=%b pkt_cnt=%0d exp 0/%0d", busy, pkt_cnt, base + 16'd1); end
    test_set = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL ts_idle_req_ready: got %b exp 0", req_ready); end
    test_set = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_request(3'd1, 3'd2, 4'd3);
    wait_ovalid(ok);
    ack_flit(0);
    give_payload(62'h0123_4567_89AB_CDEF);
    #3;
    reset = 1'b0;
    #1;
    n_checks++; if (odata !== 64'd0 || ovalid !== 1'b0 || ovch !== 2'd0) begin n_fail++; $display("FAIL rm_async_data: odata=%h ovalid=%b ovch=%0d exp 0/0/0", odata, ovalid, ovch); end
    n_checks++; if (pl_ready !== 1'b0 || busy !== 1'b0 || pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL rm_async_ctrl: pl_ready=%b busy=%b pkt_cnt=%0d exp 0/0/0", pl_ready, busy, pkt_cnt); end
    @(negedge clk);
    reset = 1'b1;
    run_packet(3'd2, 3'd2, 4'd0, 0);
    n_checks++; if (vch_q.size() != 1 || vch_q[0] !== 2'd0) begin n_fail++; $display("FAIL rm_restart_vc: got %0d exp 0", vch_q[0]); end
    n_checks++; if (flit_q[0] !== head_flit(3'd2, 3'd2, 4'd0)) begin n_fail++; $display("FAIL rm_restart_flit: got %h exp %h", flit_q[0], head_flit(3'd2, 3'd2, 4'd0)); end
    #1;
    n_checks++; if (pkt_cnt !== 16'd1) begin n_fail++; $display("FAIL rm_pkt_cnt: got %0d exp 1", pkt_cnt); end
  endtask

  initial begin
    reset = 1'b0;
    my_xpos = 3'd1; my_ypos = 3'd1;
    test_set = 1'b0;
    req_valid = 1'b0; req_dst_x = 3'd0; req_dst_y = 3'd0; req_len = 4'd0;
    pl_valid = 1'b0; pl_data = '0;
    iack = 4'b0000; irdy = 4'b1111; ilck = 4'b0000;
    for (int i = 0; i < 16; i++) pl_words[i] = '0;

    test_reset();
    test_head_only();
    test_back_to_back();
    test_payload();
    test_rr_skip();
    test_no_eligible();
    test_test_set();
    test_reset_mid();

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
